// File: rtl/div_pkg.sv
// Shared types and constants for the radix-4 divider sequencer and its
// on-the-fly quotient converter.
package div_pkg;

    localparam int NSTEPS_DEFAULT = 4;
    localparam int RW_DEFAULT     = 11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef logic signed [3:0] digit_t;

    localparam digit_t DIGIT_MIN = -4'sd2;
    localparam digit_t DIGIT_MAX = 4'sd2;

    function automatic logic digit_legal(input digit_t d);
        return (d >= DIGIT_MIN) && (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/otf_convert.sv
// On-the-fly conversion of signed radix-4 digits into the Q / QM (= Q-1) pair,
// with a sticky flag for digits outside the redundant set.
module otf_convert
    import div_pkg::*;
#(
    parameter int QW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic          err_clr,
    input  digit_t        digit,
    output logic [QW-1:0] q,
    output logic [QW-1:0] qm,
    output logic          digit_err
);

    localparam logic [QW-1:0] ONE   = QW'(1);
    localparam logic [QW-1:0] THREE = QW'(3);
    localparam logic [QW-1:0] FOUR  = QW'(4);

    logic          legal;
    digit_t        d;
    logic [QW-1:0] d_ext;
    logic [QW-1:0] q4;
    logic [QW-1:0] qm4;
    logic [QW-1:0] q_next;
    logic [QW-1:0] qm_next;

    // Illegal digits are folded to zero so the pair stays consistent.
    always_comb begin
        legal   = digit_legal(digit);
        d       = legal ? digit : 4'sd0;
        d_ext   = {{(QW-4){d[3]}}, d};
        q4      = {q[QW-3:0], 2'b00};
        qm4     = {qm[QW-3:0], 2'b00};
        q_next  = q4;
        qm_next = qm4 + THREE;
        if (d[3]) begin
            q_next  = qm4 + FOUR + d_ext;
            qm_next = qm4 + THREE + d_ext;
        end else if (d != 4'sd0) begin
            q_next  = q4 + d_ext;
            qm_next = q4 + d_ext - ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            q  <= '0;
            qm <= '0;
        end else if (en) begin
            q  <= q_next;
            qm <= qm_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || err_clr) begin
            digit_err <= 1'b0;
        end else if (en && !legal) begin
            digit_err <= 1'b1;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Control sequencer for an external radix-4 SRT datapath: loads operands,
// steps NSTEPS iterations, converts digits and applies the final correction.
module div_sequencer
    import div_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEFAULT,
    parameter int RW     = RW_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            op1,
    input  logic [7:0]            op2,
    output logic                  ready,
    output logic [7:0]            dp_op1,
    output logic [7:0]            dp_op2,
    output logic                  dp_state0,
    output logic                  dp_clk_en,
    input  logic [3:0]            dp_qdigit,
    input  logic [RW-1:0]         dp_sum,
    input  logic [RW-1:0]         dp_carry,
    output logic                  done,
    output logic [2*NSTEPS-1:0]   quotient,
    output logic [RW-1:0]         remainder,
    output logic                  div_by_zero,
    output logic                  digit_err
);

    localparam int QW = 2 * NSTEPS;
    localparam int CW = $clog2(NSTEPS + 1);

    localparam logic [2:0] IDLE = S_IDLE;
    localparam logic [2:0] LOAD = S_LOAD;
    localparam logic [2:0] ITER = S_ITER;
    localparam logic [2:0] FIX  = S_FIX;
    localparam logic [2:0] DONE = S_DONE;

    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] step;
    logic          accept;
    logic [QW-1:0] otf_q;
    logic [QW-1:0] otf_qm;
    logic [RW-1:0] r_sum;
    logic [RW-1:0] r_fix;

    assign ready     = (state == IDLE);
    assign dp_state0 = (state == LOAD);
    assign dp_clk_en = (state == LOAD) || (state == ITER);
    assign done      = (state == DONE);
    assign accept    = ready && start;

    // A negative carry-save remainder means the last digit overshot:
    // take QM and add the divisor back.
    assign r_sum = dp_sum + dp_carry;
    assign r_fix = r_sum[RW-1] ? (r_sum + RW'(dp_op2)) : r_sum;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (op2 == 8'd0) ? DONE : LOAD;
            LOAD: state_next = ITER;
            ITER: if (step == LAST_STEP) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            dp_op1      <= '0;
            dp_op2      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_op1      <= op1;
                        dp_op2      <= op2;
                        div_by_zero <= (op2 == 8'd0);
                        if (op2 == 8'd0) begin
                            quotient  <= '1;
                            remainder <= '0;
                        end
                    end
                end
                LOAD: step <= '0;
                ITER: step <= step + 1'b1;
                FIX: begin
                    quotient  <= r_sum[RW-1] ? otf_qm : otf_q;
                    remainder <= r_fix;
                end
                default: ;
            endcase
        end
    end

    otf_convert #(
        .QW(QW)
    ) u_otf (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == LOAD),
        .en        (state == ITER),
        .err_clr   (accept),
        .digit     (digit_t'(dp_qdigit)),
        .q         (otf_q),
        .qm        (otf_qm),
        .digit_err (digit_err)
    );

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed and random divisions, a digit responder
// standing in for the datapath, and a scoreboard fed from a value-level model.
module tb_div_sequencer;

    localparam int NSTEPS = 4;
    localparam int RW     = 11;
    localparam int QW     = 2 * NSTEPS;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    op1 = '0;
    logic [7:0]    op2 = '0;
    logic [3:0]    dp_qdigit = '0;
    logic [RW-1:0] dp_sum = '0;
    logic [RW-1:0] dp_carry = '0;
    logic          ready;
    logic [7:0]    dp_op1;
    logic [7:0]    dp_op2;
    logic          dp_state0;
    logic          dp_clk_en;
    logic          done;
    logic [QW-1:0] quotient;
    logic [RW-1:0] remainder;
    logic          div_by_zero;
    logic          digit_err;

    div_sequencer #(.NSTEPS(NSTEPS), .RW(RW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op1         (op1),
        .op2         (op2),
        .ready       (ready),
        .dp_op1      (dp_op1),
        .dp_op2      (dp_op2),
        .dp_state0   (dp_state0),
        .dp_clk_en   (dp_clk_en),
        .dp_qdigit   (dp_qdigit),
        .dp_sum      (dp_sum),
        .dp_carry    (dp_carry),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .digit_err   (digit_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [QW-1:0] q;
        logic [RW-1:0] r;
        logic          dbz;
        logic          derr;
        int            done_cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_exp;
    logic [3:0] dig_q[$];
    logic [7:0] cur_op1 = '0;
    logic [7:0] cur_op2 = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: quotient as the plain value sum(q_i * 4^(N-1-i)) mod 2^QW,
    // minus one when the summed remainder is negative.
    function automatic exp_t model(input logic [7:0] d2, input logic [15:0] digs,
                                   input logic [RW-1:0] s, input logic [RW-1:0] c,
                                   input int t0);
        exp_t m;
        int val;
        int d;
        logic signed [3:0] sd;
        logic [RW-1:0] r;
        m.derr = 1'b0;
        if (d2 == 8'd0) begin
            m.q = 8'hFF;
            m.r = '0;
            m.dbz = 1'b1;
            m.done_cyc = t0 + 1;
        end else begin
            val = 0;
            for (int i = 0; i < NSTEPS; i++) begin
                sd = digs[15 - 4*i -: 4];
                d = sd;
                if (d < -2 || d > 2) begin
                    m.derr = 1'b1;
                    d = 0;
                end
                val = val * 4 + d;
            end
            m.q = QW'(val);
            r = s + c;
            if (r[RW-1]) begin
                m.q = m.q - 8'd1;
                r = r + {3'b000, d2};
            end
            m.r = r;
            m.dbz = 1'b0;
            m.done_cyc = t0 + NSTEPS + 3;
        end
        return m;
    endfunction

    // ---------------- datapath responder ----------------
    always @(negedge clock) begin
        if (dp_clk_en && !dp_state0) begin
            dp_qdigit = (dig_q.size() > 0) ? dig_q.pop_front() : 4'h0;
            check("dp_op1_stable", dp_op1, cur_op1);
            check("dp_op2_stable", dp_op2, cur_op2);
        end else begin
            dp_qdigit = 4'h0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                last_exp = e;
                check("done_cycle", cyc, e.done_cyc);
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dbz);
                check("digit_err", digit_err, e.derr);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input logic [15:0] digs,
                          input logic [RW-1:0] s, input logic [RW-1:0] c);
        @(negedge clock);
        wait_ready();
        op1 = a;
        op2 = b;
        dp_sum = s;
        dp_carry = c;
        if (b != 8'd0) begin
            for (int i = 0; i < NSTEPS; i++) dig_q.push_back(digs[15 - 4*i -: 4]);
        end
        start = 1'b1;
        @(posedge clock);
        cur_op1 = a;
        cur_op2 = b;
        exp_q.push_back(model(b, digs, s, c, cyc));
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            @(negedge clock);
            k++;
        end
        if (exp_q.size() > 0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic check_hold();
        repeat (3) @(negedge clock);
        check("hold_quotient", quotient, last_exp.q);
        check("hold_remainder", remainder, last_exp.r);
        check("hold_div_by_zero", div_by_zero, last_exp.dbz);
        check("hold_digit_err", digit_err, last_exp.derr);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int en_hi;
        int done_hi;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] digs;

        // Reset held together with a start request: reset must win.
        start = 1'b1;
        op1 = 8'hAA;
        op2 = 8'h55;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_dp_op1", dp_op1, 0);
        check("rst_dp_op2", dp_op2, 0);
        check("rst_dp_state0", dp_state0, 0);
        check("rst_dp_clk_en", dp_clk_en, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        check("rst_digit_err", digit_err, 0);
        start = 1'b0;
        reset = 1'b0;

        // Digits +1,+2,0,-1 with positive and negative remainders.
        do_div(8'h64, 8'h07, 16'h120F, 11'h010, 11'h005);
        wait_idle();
        check("req23_quotient", quotient, 8'h5F);
        check("req23_remainder", remainder, 11'h015);
        check_hold();
        do_div(8'h30, 8'hC5, 16'h120F, 11'h7F0, 11'h000);
        wait_idle();
        check("req24_quotient", quotient, 8'h5E);
        check("req24_remainder", remainder, 11'h0B5);

        // Extreme digit strings.
        do_div(8'hF0, 8'h11, 16'h2222, 11'h100, 11'h001);
        do_div(8'h0F, 8'h23, 16'hEEEE, 11'h400, 11'h000);
        wait_idle();

        // Zero divisor: single-cycle path, datapath never enabled.
        do_div(8'h12, 8'h00, 16'h0000, 11'h000, 11'h000);
        en_hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (dp_clk_en) en_hi++;
            @(negedge clock);
        end
        check("zero_dp_clk_en", en_hi, 0);
        wait_idle();
        check_hold();

        // Start during ITER with different operands must be ignored.
        do_div(8'h64, 8'h07, 16'h120F, 11'h010, 11'h005);
        @(negedge clock);
        start = 1'b1;
        op1 = 8'hEE;
        op2 = 8'h33;
        @(negedge clock);
        start = 1'b0;
        check("busy_ready", ready, 0);
        check("busy_dp_op1", dp_op1, 8'h64);
        check("busy_dp_op2", dp_op2, 8'h07);
        wait_idle();
        check("busy_after_dp_op1", dp_op1, 8'h64);
        check("busy_after_quotient", quotient, 8'h5F);

        // Illegal digit in step 2 is flagged and treated as zero.
        do_div(8'h50, 8'h09, 16'h1141, 11'h020, 11'h001);
        wait_idle();
        check("derr_quotient", quotient, 8'h51);
        check("derr_flag", digit_err, 1);
        do_div(8'h10, 8'h03, 16'h1111, 11'h003, 11'h000);
        check("derr_cleared", digit_err, 0);
        wait_idle();

        // Reset in the second ITER cycle aborts with no done pulse.
        do_div(8'h77, 8'h05, 16'h2222, 11'h004, 11'h000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        dig_q.delete();
        @(negedge clock);
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_dp_clk_en", dp_clk_en, 0);
        check("abort_dp_state0", dp_state0, 0);
        check("abort_dp_op1", dp_op1, 0);
        check("abort_dp_op2", dp_op2, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        reset = 1'b0;
        done_hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) done_hi++;
        end
        check("abort_no_done", done_hi, 0);
        do_div(8'h64, 8'h07, 16'h120F, 11'h010, 11'h005);
        wait_idle();

        // Random operations issued back to back.
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            for (int i = 0; i < NSTEPS; i++) begin
                if ($urandom_range(0, 9) == 0)
                    digs[15 - 4*i -: 4] = 4'($urandom_range(3, 13));
                else
                    digs[15 - 4*i -: 4] = 4'($urandom_range(0, 4) - 2);
            end
            do_div(a, b, digs, RW'($urandom_range(0, 2047)), RW'($urandom_range(0, 2047)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter NSTEPS, default 4: the number of radix-4 iterations; the quotient width QW = 2*NSTEPS.
REQ-002 The block SHALL have parameter RW, default 11: the datapath Sum/Carry width.
REQ-003 The block SHALL have one clock, `clock`, and a synchronous active-high reset, `reset`.
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted only when ready=1
- op1  in  8  dividend
- op2  in  8  divisor
- ready  out  1  idle; can accept start
- dp_op1  out  8  registered dividend to the datapath
- dp_op2  out  8  registered divisor to the datapath
- dp_state0  out  1  datapath load select
- dp_clk_en  out  1  datapath step enable
- dp_qdigit  in  4  two's-complement quotient digit, legal range -2..+2
- dp_sum  in  RW  carry-save remainder, sum vector
- dp_carry  in  RW  carry-save remainder, carry vector
- done  out  1  one-cycle completion pulse
- quotient  out  QW  final quotient
- remainder  out  RW  corrected remainder
- div_by_zero  out  1  op2 was zero
- digit_err  out  1  sticky flag: an illegal digit was seen

Function
REQ-005 The FSM SHALL have the states IDLE, LOAD, ITER, FIX and DONE.
REQ-006 IDLE: ready=1; dp_clk_en=0.
- start=1: latch op1/op2 into dp_op1/dp_op2, clear digit_err and div_by_zero.
- op2==0: go to DONE.
- otherwise: go to LOAD.
REQ-007 LOAD: one cycle, dp_state0=1, dp_clk_en=1; clear the step counter and the Q/QM registers; next state ITER.
REQ-008 ITER: dp_state0=0, dp_clk_en=1 on every cycle for exactly NSTEPS cycles.
- dp_qdigit is sampled at each rising edge.
- After the NSTEPS-th sample, go to FIX.
REQ-009 On-the-fly conversion SHALL run for each sampled digit q, modulo 2^QW:
- q>0: Q'=4Q+q, QM'=4Q+q-1
- q=0: Q'=4Q, QM'=4QM+3
- q<0: Q'=4QM+4+q, QM'=4QM+3+q
REQ-010 An illegal digit (outside -2..+2) SHALL set digit_err and SHALL be treated as q=0.
REQ-011 FIX: one cycle, dp_clk_en=0; compute R = dp_sum + dp_carry, truncated to RW bits.
- R[RW-1]=0: quotient<=Q, remainder<=R.
- R[RW-1]=1: quotient<=QM, remainder<=R + zero-extended op2 (RW-bit wrap).
- Next state DONE.
REQ-012 DONE: done=1 for exactly one cycle; next state IDLE.
- On the zero-divisor path: quotient=all ones, remainder=0, div_by_zero=1.
REQ-013 Latency: if start is accepted at edge t, done SHALL be high in the cycle after edge t+NSTEPS+2, i.e. 7 cycles for NSTEPS=4; the zero-divisor path SHALL take 1 cycle.
REQ-014 start SHALL be ignored while ready=0; operands captured earlier SHALL not change.
REQ-015 quotient, remainder, div_by_zero and digit_err SHALL hold their values until the next accepted start.
REQ-016 dp_op1 and dp_op2 SHALL be stable from LOAD through FIX.

Reset
REQ-017 On reset=1 at a rising edge:
- state=IDLE, ready=1;
- dp_state0, dp_clk_en, done, div_by_zero and digit_err = 0;
- quotient, remainder, dp_op1, dp_op2, Q, QM and the counter = 0.
REQ-018 Reset SHALL take effect in any state, including mid-ITER; no done pulse SHALL follow an aborted operation.
REQ-019 Reset SHALL take priority over a simultaneous start.

Structure
REQ-020 Package div_pkg SHALL hold:
- the state enum;
- the NSTEPS and RW defaults;
- the legal digit range constants and the digit type.
REQ-021 On-the-fly conversion (REQ-009, REQ-010) SHALL be the sub-module otf_convert. It has a Q/QM register pair with clear and enable, digit input and digit_err output.
REQ-022 The bench SHALL drive dp_qdigit, dp_sum and dp_carry directly; no datapath instance is required.

Verification
REQ-023 Digit sequence +1,+2,0,-1, dp_sum=0x010, dp_carry=0x005 -> quotient=0x5F, remainder=0x015, done in cycle 7 after start.
REQ-024 Same digits, dp_sum=0x7F0, dp_carry=0x000, op2=0xC5 -> quotient=0x5E, remainder=0x0B5.
REQ-025 op2=0x00 -> done 1 cycle after start, quotient=0xFF, remainder=0, div_by_zero=1, dp_clk_en never high.
REQ-026 start pulsed during ITER with different operands -> ignored; dp_op1/dp_op2 and the result unchanged.
REQ-027 Digit 4'b0100 in step 2, other digits +1 -> digit_err=1, quotient=0x51; digit_err cleared by the next accepted start.
REQ-028 reset asserted in the 2nd ITER cycle -> next cycle IDLE with all outputs 0 and no done; a new start then completes normally.
